// File: rtl/move_tx.sv
// -----------------------------------------------------------------------------
// move_tx: serial transmitter for the local player's move.
//
// On an accepted tx_ready strobe the block latches the move code and the local
// colour, builds a 3-byte packet and shifts it out as UART 8N1, LSB first,
// with no gap between bytes:
//   byte0 = 8'hB0 | my_color   (sync / colour header)
//   byte1 = move                (8'hFF = pass, sent like any other code)
//   byte2 = byte0 ^ byte1       (check byte)
//
// Ports:
//   clk_in     in   system clock
//   rst_in_n   in   asynchronous active-low reset
//   tx_ready   in   one-cycle strobe requesting transmission of move
//   move       in   8-bit move code, sampled only on an accepted strobe
//   my_color   in   local colour (0 black, 1 white), sampled with move
//   tx_out     out  UART line, idle high
//   busy       out  packet in flight
//   done       out  one-cycle pulse when a packet completes
//   dropped    out  one-cycle pulse when a strobe is rejected
//   state_dbg  out  current FSM state (debug visibility only)
//
// Strobe semantics: tx_ready is a request with no back-pressure. A strobe
// seen in IDLE, or in the very last cycle of the final stop bit, is accepted
// and its move/colour are latched at that edge. A strobe seen at any other
// time is discarded and answered with a one-cycle dropped pulse; the packet
// in flight is never disturbed.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module move_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       tx_ready,
    input  logic [7:0] move,
    input  logic       my_color,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic       dropped,
    output logic [1:0] state_dbg
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [7:0]      byte0_q, byte0_d;
    logic [7:0]      byte1_q, byte1_d;
    logic [7:0]      byte2_q, byte2_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            dropped_q, dropped_d;

    logic            bit_end;
    logic            accept;
    logic [7:0]      cur_byte;
    logic [2:0]      bit_nx;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        byte2_d   = byte2_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dropped_d = 1'b0;
        accept    = 1'b0;

        bit_end = (baud_q == BAUD_LAST);
        bit_nx  = bit_q + 3'd1;

        case (byte_q)
            2'd0:    cur_byte = byte0_q;
            2'd1:    cur_byte = byte1_q;
            default: cur_byte = byte2_q;
        endcase

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                accept = tx_ready;
            end

            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = cur_byte[bit_nx];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q != 2'd2) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        // Packet complete. A strobe on this same edge is taken
                        // directly so the next start bit follows the last stop
                        // bit with no idle gap.
                        done_d = 1'b1;
                        accept = tx_ready;
                        if (!tx_ready) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase

        dropped_d = tx_ready && !accept && (state_q != S_IDLE);

        if (accept) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = 3'd0;
            byte_d  = 2'd0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            byte0_d = {7'b1011000, my_color};
            byte1_d = move;
            byte2_d = {7'b1011000, my_color} ^ move;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            byte0_q   <= 8'd0;
            byte1_q   <= 8'd0;
            byte2_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            byte0_q   <= byte0_d;
            byte1_q   <= byte1_d;
            byte2_q   <= byte2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    assign tx_out    = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dropped   = dropped_q;
    assign state_dbg = state_q;

endmodule
